// File: rtl/cpu_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory read port, issue handshake
// toward the decoder and the conditional-branch resolution input.
interface cpu_fetch_if;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic        cond_valid;
   logic        cond_taken;

   modport master (
      output imem_req, imem_addr, inst, inst_pc, inst_valid,
      input  imem_ack, imem_rdata, inst_ready, cond_valid, cond_taken
   );

   modport slave (
      input  imem_req, imem_addr, inst, inst_pc, inst_valid,
      output imem_ack, imem_rdata, inst_ready, cond_valid, cond_taken
   );
endinterface

// File: rtl/cpu_fetch.sv
// Instruction fetch unit: fetches one word at a time, issues it with a
// valid/ready handshake and steers the PC for B, CBZ/CBNZ and HALT.
module cpu_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   cpu_fetch_if.master       bus,
   output logic              halted,
   output logic [31:0]       issue_count
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_ISSUE   = 3'd2,
      S_RESOLVE = 3'd3,
      S_HALTED  = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [63:0] r_pc;
   logic [63:0] w_pc_next;
   logic [31:0] r_inst;
   logic [63:0] r_inst_pc;
   logic [31:0] r_count;
   logic        r_req;
   logic        r_valid;
   logic        r_halted;
   logic        w_xfer;
   logic        w_capture;
   logic        w_is_halt;
   logic        w_is_cb;
   logic        w_is_b;
   logic [63:0] w_b_off;
   logic [63:0] w_cb_off;
   logic [63:0] w_seq_pc;

   assign w_is_halt = (r_inst[31:21] == 11'h7FF);
   assign w_is_cb   = (r_inst[31:25] == 7'h5A);
   assign w_is_b    = (r_inst[31:26] == 6'h05);
   assign w_b_off   = {{36{r_inst[25]}}, r_inst[25:0], 2'b00};
   assign w_cb_off  = {{43{r_inst[23]}}, r_inst[23:5], 2'b00};
   assign w_seq_pc  = r_inst_pc + 64'd4;

   // Next-state and next-PC selection; decode acts on the held instruction.
   always_comb begin
      w_next    = r_state;
      w_pc_next = r_pc;
      w_xfer    = 1'b0;
      w_capture = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (run) begin
               w_next = S_FETCH;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_FETCH: begin
            if (bus.imem_ack) begin
               w_capture = 1'b1;
               w_next    = S_ISSUE;
            end else begin
               w_next = S_FETCH;
            end
         end
         S_ISSUE: begin
            if (bus.inst_ready) begin
               w_xfer = 1'b1;
               if (w_is_halt) begin
                  w_next = S_HALTED;
               end else if (w_is_cb) begin
                  w_next = S_RESOLVE;
               end else if (w_is_b) begin
                  w_pc_next = r_inst_pc + w_b_off;
                  w_next    = S_FETCH;
               end else begin
                  w_pc_next = w_seq_pc;
                  w_next    = S_FETCH;
               end
            end else begin
               w_next = S_ISSUE;
            end
         end
         S_RESOLVE: begin
            if (bus.cond_valid) begin
               if (bus.cond_taken) begin
                  w_pc_next = r_inst_pc + w_cb_off;
               end else begin
                  w_pc_next = w_seq_pc;
               end
               w_next = S_FETCH;
            end else begin
               w_next = S_RESOLVE;
            end
         end
         S_HALTED: begin
            w_next = S_HALTED;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // PC, captured instruction and saturating issue counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc      <= RESET_PC;
         r_inst    <= 32'h0;
         r_inst_pc <= 64'h0;
         r_count   <= 32'h0;
      end else begin
         r_pc <= w_pc_next;
         if (w_capture) begin
            r_inst    <= bus.imem_rdata;
            r_inst_pc <= r_pc;
         end
         if (w_xfer && (r_count != 32'hFFFF_FFFF)) begin
            r_count <= r_count + 32'd1;
         end
      end
   end

   // Status outputs registered from the upcoming state so they align with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req    <= 1'b0;
         r_valid  <= 1'b0;
         r_halted <= 1'b0;
      end else begin
         r_req    <= (w_next == S_FETCH);
         r_valid  <= (w_next == S_ISSUE);
         r_halted <= (w_next == S_HALTED);
      end
   end

   assign bus.imem_req   = r_req;
   assign bus.imem_addr  = r_pc;
   assign bus.inst       = r_inst;
   assign bus.inst_pc    = r_inst_pc;
   assign bus.inst_valid = r_valid;
   assign halted         = r_halted;
   assign issue_count    = r_count;

endmodule

// File: tb/tb_cpu_fetch.sv
// Scoreboard bench for cpu_fetch: a memory/downstream responder feeds the DUT
// while a negedge monitor checks each issued instruction against a queue.
module tb_cpu_fetch;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] word;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic        halted;
   logic [31:0] issue_count;

   cpu_fetch_if bus ();

   cpu_fetch #(.RESET_PC(64'h0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run),
      .bus         (bus),
      .halted      (halted),
      .issue_count (issue_count)
   );

   int          total;
   int          bad;
   exp_t        exp_q[$];
   logic        cond_q[$];
   logic [31:0] mem[logic [63:0]];
   int          lat;
   int          wcnt;
   int          stall_cnt;
   int          cond_wait;
   int          seen;
   logic        stall_on;
   logic        inj_ack;
   logic        inj_cond;
   logic [63:0] a_ref;
   logic [31:0] i_ref;
   logic [63:0] s_pc;
   logic [31:0] s_inst;
   logic [31:0] s_cnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Responder and monitor: drives ready, memory and branch outcome, checks issues.
   always @(negedge clk) begin
      if (bus.inst_valid && stall_cnt > 0) begin
         if (!stall_on) begin
            stall_on = 1'b1;
            s_inst   = bus.inst;
            s_pc     = bus.inst_pc;
            s_cnt    = issue_count;
         end else begin
            chk("stall_inst", {32'h0, bus.inst}, {32'h0, s_inst});
            chk("stall_pc", bus.inst_pc, s_pc);
            chk("stall_cnt", {32'h0, issue_count}, {32'h0, s_cnt});
         end
         chk("stall_no_req", {63'h0, bus.imem_req}, 64'h0);
         bus.inst_ready = 1'b0;
         stall_cnt--;
      end else begin
         bus.inst_ready = 1'b1;
         stall_on       = 1'b0;
      end

      bus.cond_valid = inj_cond;
      bus.cond_taken = 1'b0;
      if (cond_wait > 0) begin
         chk("resolve_no_req", {63'h0, bus.imem_req}, 64'h0);
         chk("resolve_no_valid", {63'h0, bus.inst_valid}, 64'h0);
         cond_wait--;
         if (cond_wait == 0) begin
            bus.cond_valid = 1'b1;
            if (cond_q.size() > 0) begin
               bus.cond_taken = cond_q.pop_front();
            end else begin
               bus.cond_taken = 1'b0;
            end
         end
      end

      if (bus.inst_valid && bus.inst_ready) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected", bus.inst_pc, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("issue_pc", bus.inst_pc, e.pc);
            chk("issue_inst", {32'h0, bus.inst}, {32'h0, e.word});
            chk("issue_count", {32'h0, issue_count}, 64'(seen));
            seen++;
            if (e.word[31:25] == 7'h5A) begin
               cond_wait = 3;
            end
         end
      end

      if (bus.imem_req) begin
         if (wcnt == 0) begin
            a_ref = bus.imem_addr;
            i_ref = bus.inst;
         end else begin
            chk("req_addr_hold", bus.imem_addr, a_ref);
            chk("inst_hold", {32'h0, bus.inst}, {32'h0, i_ref});
         end
         if (wcnt == lat) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = mem.exists(bus.imem_addr) ? mem[bus.imem_addr] : 32'h0;
         end else begin
            bus.imem_ack = 1'b0;
         end
         wcnt++;
      end else begin
         bus.imem_ack = 1'b0;
         wcnt         = 0;
      end
      bus.imem_ack = bus.imem_ack | inj_ack;
   end

   task automatic push(input logic [63:0] pc, input logic [31:0] w);
      exp_t e;
      e.pc   = pc;
      e.word = w;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      run   = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 0;
   endtask

   task automatic wait_halt(input int budget);
      int n;
      n = 0;
      while (!halted && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("halt_reached", {63'h0, halted}, 64'h1);
      run = 1'b0;
   endtask

   task automatic end_run(input int cnt);
      chk("final_count", {32'h0, issue_count}, 64'(cnt));
      chk("sb_drain", 64'(exp_q.size()), 64'h0);
      exp_q.delete();
   endtask

   initial begin
      total = 0; bad = 0; lat = 0; wcnt = 0; stall_cnt = 0; cond_wait = 0;
      seen = 0; stall_on = 1'b0; inj_ack = 1'b0; inj_cond = 1'b0;
      rst_n = 1'b0; run = 1'b0;
      bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.inst_ready = 1'b1;
      bus.cond_valid = 1'b0; bus.cond_taken = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", {63'h0, bus.imem_req}, 64'h0);
      chk("rst_addr", bus.imem_addr, 64'h0);
      chk("rst_inst", {32'h0, bus.inst}, 64'h0);
      chk("rst_inst_pc", bus.inst_pc, 64'h0);
      chk("rst_valid", {63'h0, bus.inst_valid}, 64'h0);
      chk("rst_halted", {63'h0, halted}, 64'h0);
      chk("rst_count", {32'h0, issue_count}, 64'h0);

      // Sequential ADD then HALT, zero-wait memory.
      mem.delete(); lat = 0;
      mem[64'h0] = 32'h8B01_0000; mem[64'h4] = 32'hFFE0_0000;
      push(64'h0, 32'h8B01_0000); push(64'h4, 32'hFFE0_0000);
      do_reset();
      repeat (3) @(negedge clk);
      chk("idle_no_req", {63'h0, bus.imem_req}, 64'h0);
      run = 1'b1;
      wait_halt(200);
      end_run(2);

      // HALTED ignores run, ack and cond_valid.
      inj_ack = 1'b1; inj_cond = 1'b1; run = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("halt_stay", {63'h0, halted}, 64'h1);
         chk("halt_no_req", {63'h0, bus.imem_req}, 64'h0);
         chk("halt_no_valid", {63'h0, bus.inst_valid}, 64'h0);
      end
      inj_ack = 1'b0; inj_cond = 1'b0; run = 1'b0;

      // Three-cycle memory latency.
      mem.delete(); lat = 3;
      mem[64'h0] = 32'hD503_201F; mem[64'h4] = 32'h8B01_0000; mem[64'h8] = 32'hFFE0_0000;
      push(64'h0, 32'hD503_201F); push(64'h4, 32'h8B01_0000); push(64'h8, 32'hFFE0_0000);
      do_reset(); run = 1'b1;
      wait_halt(300);
      end_run(3);

      // B with negative offset: 0x10 + (-2<<2) = 0x8.
      mem.delete(); lat = 0;
      mem[64'h0] = 32'h1400_0004; mem[64'h10] = 32'h17FF_FFFE;
      mem[64'h8] = 32'hD503_201F; mem[64'hC] = 32'hFFE0_0000;
      push(64'h0, 32'h1400_0004); push(64'h10, 32'h17FF_FFFE);
      push(64'h8, 32'hD503_201F); push(64'hC, 32'hFFE0_0000);
      do_reset(); run = 1'b1;
      wait_halt(300);
      end_run(4);

      // B with positive offset: 0x10 + 12 = 0x1C.
      mem.delete();
      mem[64'h0] = 32'h1400_0004; mem[64'h10] = 32'h1400_0003; mem[64'h1C] = 32'hFFE0_0000;
      push(64'h0, 32'h1400_0004); push(64'h10, 32'h1400_0003); push(64'h1C, 32'hFFE0_0000);
      do_reset(); run = 1'b1;
      wait_halt(300);
      end_run(3);

      // CBZ taken to 0x30, CBNZ not taken to 0x38, first issue stalled 5 cycles.
      mem.delete(); lat = 1; stall_cnt = 5;
      mem[64'h0] = 32'h1400_0008; mem[64'h20] = 32'hB400_0080; mem[64'h30] = 32'hD503_201F;
      mem[64'h34] = 32'hB500_0080; mem[64'h38] = 32'hFFE0_0000;
      push(64'h0, 32'h1400_0008); push(64'h20, 32'hB400_0080); push(64'h30, 32'hD503_201F);
      push(64'h34, 32'hB500_0080); push(64'h38, 32'hFFE0_0000);
      cond_q.push_back(1'b1); cond_q.push_back(1'b0);
      do_reset(); run = 1'b1;
      wait_halt(400);
      end_run(5);
      chk("stall_consumed", 64'(stall_cnt), 64'h0);

      // Reset in the middle of a slow fetch, then late ack/cond in IDLE.
      mem.delete(); lat = 0;
      mem[64'h0] = 32'hD503_201F; mem[64'h4] = 32'hD503_201F;
      push(64'h0, 32'hD503_201F); push(64'h4, 32'hD503_201F);
      do_reset(); run = 1'b1;
      begin
         int n;
         n = 0;
         while (seen < 2 && n < 100) begin
            @(negedge clk);
            n++;
         end
         lat = 10;
         n = 0;
         while (!bus.imem_req && n < 100) begin
            @(negedge clk);
            n++;
         end
         chk("refetch_req", {63'h0, bus.imem_req}, 64'h1);
      end
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_req", {63'h0, bus.imem_req}, 64'h0);
      chk("mid_rst_addr", bus.imem_addr, 64'h0);
      chk("mid_rst_inst", {32'h0, bus.inst}, 64'h0);
      chk("mid_rst_inst_pc", bus.inst_pc, 64'h0);
      chk("mid_rst_count", {32'h0, issue_count}, 64'h0);
      chk("mid_rst_halted", {63'h0, halted}, 64'h0);
      run = 1'b0; seen = 0;
      @(negedge clk);
      rst_n = 1'b1; inj_ack = 1'b1; inj_cond = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("late_idle_req", {63'h0, bus.imem_req}, 64'h0);
         chk("late_idle_valid", {63'h0, bus.inst_valid}, 64'h0);
      end
      inj_ack = 1'b0; inj_cond = 1'b0;
      chk("sb_after_rst", 64'(exp_q.size()), 64'h0);
      mem.delete(); lat = 0;
      mem[64'h0] = 32'hFFE0_0000;
      push(64'h0, 32'hFFE0_0000);
      run = 1'b1;
      wait_halt(200);
      end_run(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_fetch.md
CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 run  input  1  start enable; sampled only in IDLE.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  64  byte address of the requested word; equals current PC.
REQ-007 imem_ack  input  1  read complete; imem_rdata valid this cycle.
REQ-008 imem_rdata  input  32  instruction word returned by memory.
REQ-009 inst  output  32  issued instruction word; inst[31:21] drives the control decoder opcode input.
REQ-010 inst_pc  output  64  PC of the issued instruction.
REQ-011 inst_valid  output  1  inst and inst_pc are valid.
REQ-012 inst_ready  input  1  downstream accepts the instruction.
REQ-013 cond_valid  input  1  CBZ/CBNZ outcome is valid.
REQ-014 cond_taken  input  1  CBZ/CBNZ branch taken; qualified by cond_valid.
REQ-015 halted  output  1  HALT has been accepted; fetching stopped.
REQ-016 issue_count  output  32  number of accepted instructions, saturating.

Function
REQ-017 FSM states: IDLE, FETCH, ISSUE, RESOLVE, HALTED.
REQ-018 IDLE: all request/valid outputs 0; run=1 -> FETCH next cycle.
REQ-019 FETCH: imem_req=1 with imem_addr=pc, both held stable until imem_ack.
REQ-020 FETCH: on imem_ack (including ack in the first req cycle), capture imem_rdata into inst, pc into inst_pc; next state ISSUE; imem_req=0 in ISSUE.
REQ-021 ISSUE: inst_valid=1; inst and inst_pc held stable until inst_ready=1 (valid/ready handshake; transfer occurs on the cycle both are 1).
REQ-022 On transfer, classify inst in priority order: inst[31:21]=11111111111 HALT; inst[31:24]=10110100 CBZ or 10110101 CBNZ; inst[31:26]=000101 B; else sequential (including NOP 11010101000).
REQ-023 HALT -> HALTED; pc unchanged.
REQ-024 B -> pc = inst_pc + (sign_extend(inst[25:0]) << 2); next FETCH.
REQ-025 CBZ/CBNZ -> RESOLVE; pc unchanged.
REQ-026 Sequential -> pc = inst_pc + 4; next FETCH.
REQ-027 RESOLVE: inst_valid=0, imem_req=0; wait for cond_valid=1; taken -> pc = inst_pc + (sign_extend(inst[23:5]) << 2), else pc = inst_pc + 4; next FETCH.
REQ-028 cond_valid in any state other than RESOLVE is ignored.
REQ-029 All PC arithmetic is modulo 2^64; wrap-around is silent.
REQ-030 issue_count increments by 1 on each transfer (HALT included), saturates at 32'hFFFFFFFF.
REQ-031 HALTED: halted=1, imem_req=0, inst_valid=0; run, imem_ack, cond_valid ignored; exit only via reset.
REQ-032 imem_ack outside FETCH is ignored.
REQ-033 Throughput: sequential instruction with 0-wait memory and inst_ready held high issues one instruction per 2 cycles (FETCH, ISSUE).

Reset
REQ-034 rst_n=0 asynchronously forces: state IDLE, pc=RESET_PC, inst=0, inst_pc=0, imem_req=0, imem_addr=RESET_PC, inst_valid=0, halted=0, issue_count=0.
REQ-035 Reset during FETCH or RESOLVE abandons the outstanding request/resolution; a late imem_ack or cond_valid after reset release is ignored in IDLE.
REQ-036 After rst_n rises, the block remains in IDLE until run=1.

Verification
REQ-037 Reset, run=1, memory returns 8B010000 at 0, 0-wait, ready=1 -> imem_addr 0 then 4; inst_pc 0; issue_count 1.
REQ-038 imem_ack delayed 3 cycles -> imem_req and imem_addr held constant 3 cycles; inst updated only on ack cycle.
REQ-039 B at PC 0x10 with imm26=-2 (26'h3FFFFFE) -> next imem_addr 0x8; imm26=+3 -> 0x1C.
REQ-040 CBZ at PC 0x20, imm19=4: cond_taken=1 -> next addr 0x30; cond_taken=0 -> 0x24; no imem_req while in RESOLVE.
REQ-041 inst_ready low 5 cycles in ISSUE -> inst/inst_pc stable, no new imem_req, issue_count increments once.
REQ-042 HALT word FFE00000 accepted -> halted=1, imem_req=0 permanently; rst_n pulse mid-FETCH -> all outputs at reset values immediately, pc=RESET_PC.
